// File: rtl/cache_pkg.sv
// Shared definitions for the direct-mapped data cache.
// Geometry: 8 lines of 4-byte blocks addressed by an 8-bit byte address
// split as {tag[2:0], index[2:0], offset[1:0]}.
package cache_pkg;
  localparam int CACHE_LINES = 8;
  localparam int BLOCK_BYTES = 4;
  localparam int TAG_W       = 3;
  localparam int INDEX_W     = 3;
  localparam int OFFSET_W    = 2;
  localparam int BLOCK_W     = BLOCK_BYTES * 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;
endpackage

// File: rtl/cache_line_array.sv
// Line storage for the data cache: valid, dirty, tag and block data per line.
// Ports:
//   clk, rst_n        - clock, synchronous active-low clear of valid/dirty
//   rd_index          - combinational read index
//   rd_valid/dirty/tag/data - contents of the indexed line
//   bw_en/index/offset/data - byte write (store hit), sets dirty
//   fill_en/index/tag/data  - block fill from memory, sets valid, clears dirty
module cache_line_array
  import cache_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  rd_index,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [BLOCK_W-1:0]  rd_data,
  input  logic                bw_en,
  input  logic [INDEX_W-1:0]  bw_index,
  input  logic [OFFSET_W-1:0] bw_offset,
  input  logic [7:0]          bw_data,
  input  logic                fill_en,
  input  logic [INDEX_W-1:0]  fill_index,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [BLOCK_W-1:0]  fill_data
);
  logic [CACHE_LINES-1:0]              valid_q, valid_d;
  logic [CACHE_LINES-1:0]              dirty_q, dirty_d;
  logic [CACHE_LINES-1:0][TAG_W-1:0]   tag_q,   tag_d;
  logic [CACHE_LINES-1:0][BLOCK_W-1:0] data_q,  data_d;

  assign rd_valid = valid_q[rd_index];
  assign rd_dirty = dirty_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_data  = data_q[rd_index];

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_index] = 1'b1;
      dirty_d[fill_index] = 1'b0;
      tag_d[fill_index]   = fill_tag;
      data_d[fill_index]  = fill_data;
    end
    // Applied after the fill so a store never gets lost to a same-cycle fill.
    if (bw_en) begin
      dirty_d[bw_index] = 1'b1;
      data_d[bw_index][{bw_offset, 3'b000} +: 8] = bw_data;
    end
  end

  // Reset only clears the bookkeeping bits; tag/data are don't-care when
  // invalid, and holding them means a reset mid-fill updates nothing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped, write-back, write-allocate 8-bit data cache.
// Ports:
//   CLK, RESET (sync, active low)
//   CPU side : READ, WRITE, ADDRESS, WRITEDATA -> READDATA, BUSYWAIT
//   Mem side : MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA -> block
//              transfer; MEM_READDATA, MEM_BUSYWAIT <- memory response
module data_cache
  import cache_pkg::*;
(
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        READ,
  input  logic                        WRITE,
  input  logic [7:0]                  ADDRESS,
  input  logic [7:0]                  WRITEDATA,
  output logic [7:0]                  READDATA,
  output logic                        BUSYWAIT,
  output logic                        MEM_READ,
  output logic                        MEM_WRITE,
  output logic [TAG_W+INDEX_W-1:0]    MEM_ADDRESS,
  output logic [BLOCK_W-1:0]          MEM_WRITEDATA,
  input  logic [BLOCK_W-1:0]          MEM_READDATA,
  input  logic                        MEM_BUSYWAIT
);
  state_e state_q, state_d;

  logic [TAG_W-1:0]    addr_tag;
  logic [INDEX_W-1:0]  addr_index;
  logic [OFFSET_W-1:0] addr_offset;
  logic                line_valid, line_dirty;
  logic [TAG_W-1:0]    line_tag;
  logic [BLOCK_W-1:0]  line_data;
  logic                req, hit;
  logic                bw_en, fill_en;

  assign addr_tag    = ADDRESS[7:5];
  assign addr_index  = ADDRESS[4:2];
  assign addr_offset = ADDRESS[1:0];

  cache_line_array u_lines (
    .clk        (CLK),
    .rst_n      (RESET),
    .rd_index   (addr_index),
    .rd_valid   (line_valid),
    .rd_dirty   (line_dirty),
    .rd_tag     (line_tag),
    .rd_data    (line_data),
    .bw_en      (bw_en),
    .bw_index   (addr_index),
    .bw_offset  (addr_offset),
    .bw_data    (WRITEDATA),
    .fill_en    (fill_en),
    .fill_index (addr_index),
    .fill_tag   (addr_tag),
    .fill_data  (MEM_READDATA)
  );

  assign req      = READ | WRITE;
  assign hit      = line_valid && (line_tag == addr_tag);
  assign BUSYWAIT = req & ~((state_q == IDLE) & hit);
  assign READDATA = READ ? line_data[{addr_offset, 3'b000} +: 8] : 8'h00;
  // Only meaningful during WRITEBACK; the victim is simply the indexed line.
  assign MEM_WRITEDATA = line_data;

  always_comb begin
    state_d     = state_q;
    MEM_READ    = 1'b0;
    MEM_WRITE   = 1'b0;
    MEM_ADDRESS = {addr_tag, addr_index};
    bw_en       = 1'b0;
    fill_en     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (hit) bw_en = WRITE;  // READ&WRITE together behaves as a store
          else if (line_valid && line_dirty) state_d = WRITEBACK;
          else state_d = FETCH;
        end
      end
      WRITEBACK: begin
        MEM_WRITE   = 1'b1;
        MEM_ADDRESS = {line_tag, addr_index};
        if (!MEM_BUSYWAIT) state_d = FETCH;
      end
      FETCH: begin
        MEM_READ = 1'b1;
        if (!MEM_BUSYWAIT) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET) state_q <= IDLE;
    else        state_q <= state_d;
  end
endmodule

// File: tb/tb_data_cache.sv
module tb_data_cache;
  logic        CLK = 1'b0;
  logic        RESET, READ, WRITE, MEM_BUSYWAIT;
  logic [7:0]  ADDRESS, WRITEDATA, READDATA;
  logic        BUSYWAIT, MEM_READ, MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA, MEM_READDATA;

  int tests = 0;
  int fails = 0;

  data_cache dut (
    .CLK(CLK), .RESET(RESET), .READ(READ), .WRITE(WRITE),
    .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
    .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
    .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
    .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge, then back to the falling edge where inputs change.
  task automatic cyc();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RESET = 1'b0; READ = 1'b0; WRITE = 1'b0; ADDRESS = 8'h00; WRITEDATA = 8'h00;
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h0;
    @(negedge CLK);
    cyc(); #1;
    chk("rst_mem_read", MEM_READ, 0);
    chk("rst_mem_write", MEM_WRITE, 0);
    chk("rst_busywait", BUSYWAIT, 0);
    chk("rst_readdata", READDATA, 8'h00);
    RESET = 1'b1;

    // Read 0x25: clean miss, one FETCH at 0x09.
    @(negedge CLK); READ = 1'b1; ADDRESS = 8'h25; #1;
    chk("miss_busy", BUSYWAIT, 1);
    chk("miss_idle_memread", MEM_READ, 0);
    cyc(); #1;
    chk("fetch_memread", MEM_READ, 1);
    chk("fetch_memwrite", MEM_WRITE, 0);
    chk("fetch_addr", MEM_ADDRESS, 6'h09);
    MEM_BUSYWAIT = 1'b1;
    cyc(); #1;
    chk("fetch_hold", MEM_READ, 1);
    chk("fetch_busy", BUSYWAIT, 1);
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'hDDCCBBAA;
    cyc(); #1;
    chk("fill_readdata", READDATA, 8'hBB);
    chk("fill_busy", BUSYWAIT, 0);
    chk("fill_memread", MEM_READ, 0);

    // Write hit 0x5A at 0x25, then read it back.
    @(negedge CLK); READ = 1'b0; WRITE = 1'b1; WRITEDATA = 8'h5A; #1;
    chk("whit_busy", BUSYWAIT, 0);
    chk("whit_readdata_zero", READDATA, 8'h00);
    chk("whit_mem", {MEM_READ, MEM_WRITE}, 2'b00);
    cyc(); WRITE = 1'b0; READ = 1'b1; #1;
    chk("rhit_data", READDATA, 8'h5A);
    chk("rhit_busy", BUSYWAIT, 0);

    // Read 0xA5: dirty victim written back, then FETCH at 0x29.
    ADDRESS = 8'hA5; #1;
    chk("dmiss_busy", BUSYWAIT, 1);
    cyc(); #1;
    chk("wb_memwrite", MEM_WRITE, 1);
    chk("wb_memread", MEM_READ, 0);
    chk("wb_addr", MEM_ADDRESS, 6'h09);
    chk("wb_data", MEM_WRITEDATA, 32'hDDCC5AAA);
    MEM_BUSYWAIT = 1'b1;
    cyc(); #1;
    chk("wb_hold", MEM_WRITE, 1);
    chk("wb_hold_addr", MEM_ADDRESS, 6'h09);
    MEM_BUSYWAIT = 1'b0;
    cyc(); #1;
    chk("wb_fetch_memread", MEM_READ, 1);
    chk("wb_fetch_memwrite", MEM_WRITE, 0);
    chk("wb_fetch_addr", MEM_ADDRESS, 6'h29);
    MEM_BUSYWAIT = 1'b1;
    cyc();
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h44332211;
    cyc(); #1;
    chk("dmiss_readdata", READDATA, 8'h22);
    chk("dmiss_busy_done", BUSYWAIT, 0);

    // Write miss to 0x40: allocate, then store byte 0.
    READ = 1'b0; WRITE = 1'b1; ADDRESS = 8'h40; WRITEDATA = 8'h77; #1;
    chk("wmiss_busy", BUSYWAIT, 1);
    cyc(); #1;
    chk("wmiss_fetch", MEM_READ, 1);
    chk("wmiss_addr", MEM_ADDRESS, 6'h10);
    MEM_BUSYWAIT = 1'b1;
    cyc();
    MEM_BUSYWAIT = 1'b0; MEM_READDATA = 32'h0D0C0B0A;
    cyc(); #1;
    chk("wmiss_hit_busy", BUSYWAIT, 0);
    cyc(); WRITE = 1'b0; READ = 1'b1; #1;
    chk("wmiss_readback", READDATA, 8'h77);
    // Evict it via 0x60 (same index); zero-latency memory.
    ADDRESS = 8'h60; #1;
    chk("evict_busy", BUSYWAIT, 1);
    cyc(); #1;
    chk("evict_wb", MEM_WRITE, 1);
    chk("evict_addr", MEM_ADDRESS, 6'h10);
    chk("evict_data", MEM_WRITEDATA, 32'h0D0C0B77);
    MEM_READDATA = 32'h99999999;
    cyc(); #1;
    chk("evict_fetch", MEM_READ, 1);
    chk("evict_fetch_addr", MEM_ADDRESS, 6'h18);
    cyc(); #1;
    chk("evict_readdata", READDATA, 8'h99);
    chk("evict_busy_done", BUSYWAIT, 0);

    // Reset during FETCH of 0x84 (line 1 holds clean tag 5).
    ADDRESS = 8'h84; #1;
    chk("rmid_busy", BUSYWAIT, 1);
    cyc(); #1;
    chk("rmid_fetch", MEM_READ, 1);
    MEM_BUSYWAIT = 1'b1; RESET = 1'b0;
    cyc(); RESET = 1'b1; #1;
    chk("rmid_memread_drop", MEM_READ, 0);
    chk("rmid_memwrite", MEM_WRITE, 0);
    MEM_BUSYWAIT = 1'b0;
    ADDRESS = 8'hA5; #1;
    chk("rmid_old_line_gone", BUSYWAIT, 1);
    ADDRESS = 8'h84; #1;
    chk("rmid_remiss", BUSYWAIT, 1);
    cyc(); #1;
    chk("rmid_refetch", MEM_READ, 1);
    chk("rmid_refetch_addr", MEM_ADDRESS, 6'h21);
    MEM_READDATA = 32'h04030201;
    cyc(); #1;
    chk("rmid_readdata", READDATA, 8'h01);

    // READ and WRITE together on a hit: store happens, no stall.
    ADDRESS = 8'h86; WRITE = 1'b1; WRITEDATA = 8'hE7; #1;
    chk("rw_busy", BUSYWAIT, 0);
    chk("rw_readdata_old", READDATA, 8'h03);
    cyc(); WRITE = 1'b0; #1;
    chk("rw_readback", READDATA, 8'hE7);
    chk("rw_mem_idle", {MEM_READ, MEM_WRITE}, 2'b00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
